// File: rtl/alu_seq.sv
// Handshaked unsigned ALU: single-cycle NOP/MUL/ADD/SUB plus an iterative restoring divider.
// Results and flags are registered and held in DONE until the consumer accepts them.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zflag,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvsr, quo, rem;
  logic               accept, start_div;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res;
  logic               res_ovf, res_dz, res_err;

  logic [WIDTH:0]     rem_sh, trial;
  logic               take;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign start_div = (alu_ctrl == 3'b100) && (in2 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = start_div ? DIV : DONE;
      DIV:  if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = !in_valid ? IDLE : (start_div ? DIV : DONE);
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod    = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    res     = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    res_err = 1'b0;
    case (alu_ctrl)
      3'b000: res = out;
      3'b001: begin
        res_ovf = |prod[2*WIDTH-1:WIDTH];
        res     = (SAT && res_ovf) ? '1 : prod[WIDTH-1:0];
      end
      3'b010: begin
        res_ovf = sum[WIDTH];
        res     = (SAT && res_ovf) ? '1 : sum[WIDTH-1:0];
      end
      3'b011: begin
        res_ovf = diff[WIDTH];
        res     = (SAT && res_ovf) ? '0 : diff[WIDTH-1:0];
      end
      // Only the divide-by-zero case completes here; non-zero divisors go through DIV.
      3'b100: begin
        res    = '1;
        res_dz = 1'b1;
      end
      default: res_err = 1'b1;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvsr};
    take    = !trial[WIDTH];
    rem_nxt = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      zflag <= 1'b1;
      ovf   <= 1'b0;
      dz    <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      dvsr  <= '0;
      quo   <= '0;
      rem   <= '0;
    end else if (accept) begin
      if (start_div) begin
        dvsr <= in2;
        quo  <= in1;
        rem  <= '0;
        cnt  <= CW'(WIDTH - 1);
      end else begin
        out   <= res;
        zflag <= (res == '0);
        ovf   <= res_ovf;
        dz    <= res_dz;
        err   <= res_err;
      end
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        out   <= quo_nxt;
        zflag <= (quo_nxt == '0);
        ovf   <= 1'b0;
        dz    <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: wrapping and saturating instances driven in lockstep and
// compared against an arithmetic reference model of each opcode.
module tb_alu_seq;

  localparam int unsigned W = 16;
  localparam longint unsigned MAXV = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [2:0] alu_ctrl = '0;

  logic in_ready0, out_valid0, z0, ovf0, dz0, err0;
  logic in_ready1, out_valid1, z1, ovf1, dz1, err1;
  logic [W-1:0] out0, out1;

  alu_seq #(.WIDTH(W), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .out_valid(out_valid0),
    .out_ready(out_ready), .out(out0), .zflag(z0), .ovf(ovf0), .dz(dz0), .err(err0)
  );

  alu_seq #(.WIDTH(W), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1), .zflag(z1), .ovf(ovf1), .dz(dz1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned out;
    bit z, ovf, dz, err;
  } res_t;

  int n_checks = 0;
  int n_errors = 0;

  res_t exp0, exp1;
  longint unsigned prev0 = 0, prev1 = 0;
  int unsigned cur_op;
  longint unsigned cur_a, cur_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  function automatic res_t model(input int unsigned op, input longint unsigned a,
                                 input longint unsigned b, input bit sat,
                                 input longint unsigned prev);
    res_t r;
    longint unsigned full;
    r.out = 0; r.ovf = 0; r.dz = 0; r.err = 0;
    case (op)
      0: r.out = prev;
      1: begin
        full  = a * b;
        r.ovf = full > MAXV;
        r.out = (sat && r.ovf) ? MAXV : full % (MAXV + 1);
      end
      2: begin
        full  = a + b;
        r.ovf = full > MAXV;
        r.out = (sat && r.ovf) ? MAXV : full % (MAXV + 1);
      end
      3: begin
        r.ovf = a < b;
        r.out = (sat && r.ovf) ? 0 : (a + MAXV + 1 - b) % (MAXV + 1);
      end
      4: begin
        if (b == 0) begin
          r.out = MAXV;
          r.dz  = 1;
        end else begin
          r.out = a / b;
        end
      end
      default: r.err = 1;
    endcase
    r.z = (r.out == 0);
    return r;
  endfunction

  // Present a request (retiring any pending result on the same edge) and wait for acceptance.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = op; in1 = a; in2 = b; out_ready = 1'b1;
    #1;
    w = 0;
    while (!in_ready0 && w < 50) begin
      @(negedge clk); #1; w++;
    end
    check("issue_in_ready_immediate", 64'(w), 64'd0);
    cur_op = op; cur_a = a; cur_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); alu_ctrl = 3'($urandom);
  endtask

  task automatic wait_result();
    int lat;
    int exp_lat;
    lat = 1;
    while (!out_valid0 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    exp_lat = (cur_op == 4 && cur_b != 0) ? W + 1 : 1;
    check("latency", 64'(lat), 64'(exp_lat));
    exp0 = model(cur_op, cur_a, cur_b, 1'b0, prev0);
    exp1 = model(cur_op, cur_a, cur_b, 1'b1, prev1);
    check("valid_sat", {63'd0, out_valid1}, 64'd1);
    check("out_wrap", {48'd0, out0}, exp0.out);
    check("flags_wrap", {60'd0, z0, ovf0, dz0, err0}, {60'd0, exp0.z, exp0.ovf, exp0.dz, exp0.err});
    check("out_sat", {48'd0, out1}, exp1.out);
    check("flags_sat", {60'd0, z1, ovf1, dz1, err1}, {60'd0, exp1.z, exp1.ovf, exp1.dz, exp1.err});
    prev0 = exp0.out;
    prev1 = exp1.out;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_result();
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, out_valid0}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready0}, 64'd0);
      check("hold_out", {48'd0, out0}, prev0);
      check("hold_flags", {60'd0, z0, ovf0, dz0, err0}, {60'd0, exp0.z, exp0.ovf, exp0.dz, exp0.err});
      check("hold_out_sat", {48'd0, out1}, prev1);
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_valid", {63'd0, out_valid0}, 64'd0);
    check("retire_in_ready", {63'd0, in_ready0}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [W-1:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {48'd0, out0}, 64'd0);
    check("rst_flags", {60'd0, z0, ovf0, dz0, err0}, 64'b1000);
    check("rst_valid", {63'd0, out_valid0}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {63'd0, in_ready0}, 64'd1);

    run_op(3'b010, 16'hFFFF, 16'h0002);
    run_op(3'b011, 16'h1234, 16'h1234);
    run_op(3'b011, 16'd3, 16'd5);
    run_op(3'b100, 16'd1000, 16'd7);
    run_op(3'b100, 16'd5, 16'd0);
    run_op(3'b001, 16'h0100, 16'h0100);
    run_op(3'b110, 16'h1111, 16'h2222);
    run_op(3'b010, 16'd10, 16'd20);
    run_op(3'b000, 16'hABCD, 16'h0000);
    run_op(3'b100, 16'hFFFF, 16'hFFFF);
    run_op(3'b100, 16'd3, 16'd9);
    run_op(3'b010, 16'd7, 16'd8);
    hold(5);
    run_op(3'b011, 16'd100, 16'd1);
    retire();
    run_op(3'b000, 16'd0, 16'd0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      run_op(op, a, b);
      hold($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) retire();
    end

    // Abort a divide partway through with an asynchronous reset.
    issue(3'b100, 16'd40000, 16'd3);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out", {48'd0, out0}, 64'd0);
    check("abort_valid", {63'd0, out_valid0}, 64'd0);
    check("abort_zflag", {63'd0, z0}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    prev0 = 0; prev1 = 0;
    @(posedge clk); #1;
    check("abort_in_ready", {63'd0, in_ready0}, 64'd1);
    check("abort_no_result", {63'd0, out_valid0}, 64'd0);
    run_op(3'b010, 16'd2, 16'd2);
    check("post_abort_add", {48'd0, out0}, 64'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
